id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and
// a saturating count of hazard bubbles.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Id_valid,
   input  logic [31:0] Id_pc,
   input  logic [31:0] Imm_ext,
   input  logic [31:0] Rs1_data,
   input  logic [31:0] Rs2_data,
   input  logic [4:0]  Rs1_addr,
   input  logic [4:0]  Rs2_addr,
   input  logic [4:0]  Rd_addr,
   input  logic        Uses_rs1,
   input  logic        Uses_rs2,
   input  logic [3:0]  Alu_op,
   input  logic        Alu_src,
   input  logic        Mem_read,
   input  logic        Mem_write,
   input  logic        Reg_write,
   input  logic        Flush,
   input  logic        Stall_ex,
   output logic        Ex_valid,
   output logic [31:0] Ex_pc,
   output logic [31:0] Ex_imm,
   output logic [31:0] Ex_rs1_data,
   output logic [31:0] Ex_rs2_data,
   output logic [4:0]  Ex_rs1_addr,
   output logic [4:0]  Ex_rs2_addr,
   output logic [4:0]  Ex_rd_addr,
   output logic [3:0]  Ex_alu_op,
   output logic        Ex_alu_src,
   output logic        Ex_mem_read,
   output logic        Ex_mem_write,
   output logic        Ex_reg_write,
   output logic        Stall_id,
   output logic [15:0] Bubble_count
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } ex_t;

   ex_t         ex_q, ex_d;
   logic [15:0] bubble_q, bubble_d;
   logic        hz;

   // A bubble in EX (valid=0) can never be the producer of a hazard.
   assign hz = ex_q.valid && ex_q.mem_read && Id_valid && (ex_q.rd_addr != 5'd0) &&
               ((Uses_rs1 && (Rs1_addr == ex_q.rd_addr)) ||
                (Uses_rs2 && (Rs2_addr == ex_q.rd_addr)));

   // Gated by rst_n so an external Stall_ex cannot raise a stall during reset.
   assign Stall_id = rst_n && (hz || Stall_ex) && !Flush;

   always_comb begin
      ex_d     = ex_q;
      bubble_d = bubble_q;
      if (Flush || (!Stall_ex && hz)) begin
         ex_d.valid     = 1'b0;
         ex_d.mem_read  = 1'b0;
         ex_d.mem_write = 1'b0;
         ex_d.reg_write = 1'b0;
         if (!Flush && bubble_q != 16'hFFFF)
            bubble_d = bubble_q + 16'd1;
      end else if (!Stall_ex) begin
         ex_d.valid     = Id_valid;
         ex_d.pc        = Id_pc;
         ex_d.imm       = Imm_ext;
         ex_d.rs1_data  = Rs1_data;
         ex_d.rs2_data  = Rs2_data;
         ex_d.rs1_addr  = Rs1_addr;
         ex_d.rs2_addr  = Rs2_addr;
         ex_d.rd_addr   = Rd_addr;
         ex_d.alu_op    = Alu_op;
         ex_d.alu_src   = Alu_src;
         ex_d.mem_read  = Mem_read  && Id_valid;
         ex_d.mem_write = Mem_write && Id_valid;
         ex_d.reg_write = Reg_write && Id_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= '0;
         bubble_q <= '0;
      end else begin
         ex_q     <= ex_d;
         bubble_q <= bubble_d;
      end
   end

   assign Ex_valid     = ex_q.valid;
   assign Ex_pc        = ex_q.pc;
   assign Ex_imm       = ex_q.imm;
   assign Ex_rs1_data  = ex_q.rs1_data;
   assign Ex_rs2_data  = ex_q.rs2_data;
   assign Ex_rs1_addr  = ex_q.rs1_addr;
   assign Ex_rs2_addr  = ex_q.rs2_addr;
   assign Ex_rd_addr   = ex_q.rd_addr;
   assign Ex_alu_op    = ex_q.alu_op;
   assign Ex_alu_src   = ex_q.alu_src;
   assign Ex_mem_read  = ex_q.mem_read;
   assign Ex_mem_write = ex_q.mem_write;
   assign Ex_reg_write = ex_q.reg_write;
   assign Bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, load-use bubble, x0/unused source,
// flush priority, hold, counter saturation and asynchronous reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Id_valid, Alu_src, Mem_read, Mem_write, Reg_write;
   logic [31:0] Id_pc, Imm_ext, Rs1_data, Rs2_data;
   logic [4:0]  Rs1_addr, Rs2_addr, Rd_addr;
   logic        Uses_rs1, Uses_rs2, Flush, Stall_ex;
   logic [3:0]  Alu_op;
   logic        Ex_valid, Ex_alu_src, Ex_mem_read, Ex_mem_write, Ex_reg_write;
   logic [31:0] Ex_pc, Ex_imm, Ex_rs1_data, Ex_rs2_data;
   logic [4:0]  Ex_rs1_addr, Ex_rs2_addr, Ex_rd_addr;
   logic [3:0]  Ex_alu_op;
   logic        Stall_id;
   logic [15:0] Bubble_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .Id_valid(Id_valid), .Id_pc(Id_pc), .Imm_ext(Imm_ext),
      .Rs1_data(Rs1_data), .Rs2_data(Rs2_data), .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
      .Rd_addr(Rd_addr), .Uses_rs1(Uses_rs1), .Uses_rs2(Uses_rs2), .Alu_op(Alu_op),
      .Alu_src(Alu_src), .Mem_read(Mem_read), .Mem_write(Mem_write), .Reg_write(Reg_write),
      .Flush(Flush), .Stall_ex(Stall_ex), .Ex_valid(Ex_valid), .Ex_pc(Ex_pc), .Ex_imm(Ex_imm),
      .Ex_rs1_data(Ex_rs1_data), .Ex_rs2_data(Ex_rs2_data), .Ex_rs1_addr(Ex_rs1_addr),
      .Ex_rs2_addr(Ex_rs2_addr), .Ex_rd_addr(Ex_rd_addr), .Ex_alu_op(Ex_alu_op),
      .Ex_alu_src(Ex_alu_src), .Ex_mem_read(Ex_mem_read), .Ex_mem_write(Ex_mem_write),
      .Ex_reg_write(Ex_reg_write), .Stall_id(Stall_id), .Bubble_count(Bubble_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Id_valid = 0; Id_pc = 0; Imm_ext = 0; Rs1_data = 0; Rs2_data = 0;
      Rs1_addr = 0; Rs2_addr = 0; Rd_addr = 0; Uses_rs1 = 0; Uses_rs2 = 0;
      Alu_op = 0; Alu_src = 0; Mem_read = 0; Mem_write = 0; Reg_write = 0;
      Flush = 0; Stall_ex = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a valid load writing rd into ID.
   task automatic drive_load(input logic [4:0] rd, input logic [31:0] pc);
      idle();
      Id_valid = 1; Id_pc = pc; Rd_addr = rd; Mem_read = 1; Reg_write = 1; Alu_src = 1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      Stall_ex = 1;
      #12;
      chk("rst_ex_valid", {31'd0, Ex_valid}, 32'd0);
      chk("rst_ex_pc", Ex_pc, 32'd0);
      chk("rst_bubble", {16'd0, Bubble_count}, 32'd0);
      chk("rst_stall_id", {31'd0, Stall_id}, 32'd0);
      @(negedge clk);
      Stall_ex = 0;
      rst_n = 1;

      // Normal load
      idle();
      Id_valid = 1; Id_pc = 32'h100; Imm_ext = 32'hFFFFF800; Rd_addr = 5; Reg_write = 1;
      Rs1_data = 32'hDEADBEEF; Alu_op = 4'hA;
      tick();
      chk("ld_valid", {31'd0, Ex_valid}, 32'd1);
      chk("ld_imm", Ex_imm, 32'hFFFFF800);
      chk("ld_rd", {27'd0, Ex_rd_addr}, 32'd5);
      chk("ld_regwr", {31'd0, Ex_reg_write}, 32'd1);
      chk("ld_pc", Ex_pc, 32'h100);
      chk("ld_rs1d", Ex_rs1_data, 32'hDEADBEEF);
      chk("ld_aluop", {28'd0, Ex_alu_op}, 32'hA);

      // Invalid ID forces enables low
      idle();
      Id_pc = 32'h104; Mem_read = 1; Mem_write = 1; Reg_write = 1;
      tick();
      chk("inv_valid", {31'd0, Ex_valid}, 32'd0);
      chk("inv_en", {29'd0, Ex_mem_read, Ex_mem_write, Ex_reg_write}, 32'd0);
      chk("inv_pc", Ex_pc, 32'h104);

      // Load-use: one bubble then the dependent instruction loads
      drive_load(5'd7, 32'h200);
      tick();
      idle();
      Id_valid = 1; Id_pc = 32'h204; Uses_rs1 = 1; Rs1_addr = 7; Rd_addr = 8; Reg_write = 1;
      #1;
      chk("lu_stall", {31'd0, Stall_id}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'd0, Ex_valid}, 32'd0);
      chk("lu_count", {16'd0, Bubble_count}, 32'd1);
      chk("lu_stall_after", {31'd0, Stall_id}, 32'd0);
      tick();
      chk("lu_load_valid", {31'd0, Ex_valid}, 32'd1);
      chk("lu_load_rd", {27'd0, Ex_rd_addr}, 32'd8);
      chk("lu_count_hold", {16'd0, Bubble_count}, 32'd1);

      // x0 destination never stalls
      drive_load(5'd0, 32'h300);
      tick();
      idle();
      Id_valid = 1; Uses_rs1 = 1; Rs1_addr = 0;
      #1;
      chk("x0_stall", {31'd0, Stall_id}, 32'd0);

      // Unused source never stalls; used one does
      drive_load(5'd7, 32'h310);
      tick();
      idle();
      Id_valid = 1; Uses_rs2 = 0; Rs2_addr = 7;
      #1;
      chk("unused_rs2_stall", {31'd0, Stall_id}, 32'd0);
      Uses_rs2 = 1;
      #1;
      chk("used_rs2_stall", {31'd0, Stall_id}, 32'd1);

      // Flush beats Stall_ex and hz
      Flush = 1; Stall_ex = 1; Reg_write = 1;
      #1;
      chk("fl_stall_id", {31'd0, Stall_id}, 32'd0);
      tick();
      chk("fl_valid", {31'd0, Ex_valid}, 32'd0);
      chk("fl_regwr", {31'd0, Ex_reg_write}, 32'd0);
      chk("fl_count", {16'd0, Bubble_count}, 32'd1);

      // Hold for 3 cycles under Stall_ex, with a hazard pending underneath
      drive_load(5'd9, 32'h400);
      Imm_ext = 32'h1234;
      tick();
      idle();
      Stall_ex = 1; Id_valid = 1; Uses_rs1 = 1; Rs1_addr = 9; Id_pc = 32'h999; Imm_ext = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", {31'd0, Ex_valid}, 32'd1);
         chk("hold_pc", Ex_pc, 32'h400);
         chk("hold_imm", Ex_imm, 32'h1234);
         chk("hold_rd", {27'd0, Ex_rd_addr}, 32'd9);
         chk("hold_count", {16'd0, Bubble_count}, 32'd1);
         chk("hold_stall_id", {31'd0, Stall_id}, 32'd1);
      end

      // Saturation: preload counter just below the ceiling
      force dut.bubble_q = 16'hFFFE;
      #1;
      release dut.bubble_q;
      #1;
      chk("sat_preset", {16'd0, Bubble_count}, 32'h0000FFFE);
      Stall_ex = 0;
      tick();
      chk("sat_reach", {16'd0, Bubble_count}, 32'h0000FFFF);
      drive_load(5'd9, 32'h410);
      tick();
      idle();
      Id_valid = 1; Uses_rs1 = 1; Rs1_addr = 9;
      tick();
      chk("sat_bubble", {31'd0, Ex_valid}, 32'd0);
      chk("sat_hold", {16'd0, Bubble_count}, 32'h0000FFFF);

      // Async reset mid-stall, no clock edge needed
      drive_load(5'd3, 32'h500);
      tick();
      chk("ar_pre_valid", {31'd0, Ex_valid}, 32'd1);
      Stall_ex = 1;
      #2;
      chk("ar_pre_stall", {31'd0, Stall_id}, 32'd1);
      rst_n = 0;
      #1;
      chk("ar_valid", {31'd0, Ex_valid}, 32'd0);
      chk("ar_count", {16'd0, Bubble_count}, 32'd0);
      chk("ar_pc", Ex_pc, 32'd0);
      chk("ar_stall_id", {31'd0, Stall_id}, 32'd0);
      @(negedge clk);
      idle();
      Id_valid = 1; Id_pc = 32'h600; Rd_addr = 4; Reg_write = 1;
      rst_n = 1;
      tick();
      chk("post_rst_valid", {31'd0, Ex_valid}, 32'd1);
      chk("post_rst_pc", Ex_pc, 32'h600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
